// File: rtl/spi_cfg_regbank_if.sv
// SPI pin bundle between the external host (master) and the configuration
// register bank (slave).
interface spi_cfg_regbank_if;
    logic SPI_SCK;
    logic SPI_CSN;
    logic SPI_MOSI;
    logic SPI_MISO;

    modport master (
        output SPI_SCK,
        output SPI_CSN,
        output SPI_MOSI,
        input  SPI_MISO
    );

    modport slave (
        input  SPI_SCK,
        input  SPI_CSN,
        input  SPI_MOSI,
        output SPI_MISO
    );
endinterface

// File: rtl/spi_cfg_regbank.sv
// SPI slave feeding a shadow register bank; a load event copies every shadow
// register into the active bank in one cycle so the PLL never sees a half-update.
module spi_cfg_regbank #(
    parameter int                  NREG      = 16,
    parameter logic [16*NREG-1:0]  RST_VAL   = {16*NREG{1'b0}},
    parameter logic [6:0]          LOAD_ADDR = 7'h7F
) (
    input  logic                 CLK,
    input  logic                 RST,
    spi_cfg_regbank_if.slave     spi,
    input  logic                 SPI_CONFIG,
    output logic [16*NREG-1:0]   CFG_BUS,
    output logic                 CFG_UPD,
    output logic [7:0]           ABORT_CNT
);

    localparam int         BW     = 16 * NREG;
    localparam logic [7:0] NREG_W = 8'(NREG);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'h01;
    endfunction

    state_t          state_r, state_s;
    logic            sck_meta_r, sck_sync_r, sck_prev_r;
    logic            csn_meta_r, csn_sync_r, csn_prev_r;
    logic            mosi_meta_r, mosi_sync_r;
    logic [1:0]      vld_r;
    logic            armed_r;
    logic [4:0]      cnt_r;
    logic [23:0]     shift_r;
    logic [15:0]     miso_sr_r;
    logic            miso_r;
    logic [BW-1:0]   shadow_r;
    logic [BW-1:0]   active_r;
    logic            cfg_prev_r;
    logic            load_pend_r;
    logic            upd_arm_r;
    logic            cfg_upd_r;
    logic [7:0]      abort_r;

    logic            sck_rise_s, sck_fall_s, csn_fall_s, csn_rise_s;
    logic [23:0]     shift_next_s;
    logic            frame_w_s;
    logic [6:0]      frame_addr_s;
    logic [15:0]     frame_data_s;
    logic            full_s, commit_s;
    logic            wr_hit_s, load_cmd_s, abort_s;
    logic            rd_latch_s;
    logic [6:0]      rd_addr_s;
    logic [15:0]     rd_data_s;
    logic            cfg_rise_s, load_req_s;

    assign sck_rise_s   = sck_sync_r & ~sck_prev_r;
    assign sck_fall_s   = ~sck_sync_r & sck_prev_r;
    // A CSN already low when reset ends must not look like a frame start.
    assign csn_fall_s   = ~csn_sync_r & csn_prev_r & armed_r;
    assign csn_rise_s   = csn_sync_r & ~csn_prev_r;

    assign shift_next_s = {shift_r[22:0], mosi_sync_r};
    assign frame_w_s    = shift_r[23];
    assign frame_addr_s = shift_r[22:16];
    assign frame_data_s = shift_r[15:0];
    assign commit_s     = (state_r == ST_COMMIT);
    assign full_s       = (cnt_r == 5'd24);
    assign wr_hit_s     = commit_s & full_s & frame_w_s & ({1'b0, frame_addr_s} < NREG_W);
    assign load_cmd_s   = commit_s & full_s & frame_w_s & (frame_addr_s == LOAD_ADDR);
    assign abort_s      = commit_s & ~full_s;

    // The 8th rising edge completes the header: W sits in shift_r[6].
    assign rd_latch_s   = (state_r == ST_SHIFT) & sck_rise_s & (cnt_r == 5'd7) & ~shift_r[6];
    assign rd_addr_s    = {shift_r[5:0], mosi_sync_r};

    assign cfg_rise_s   = SPI_CONFIG & ~cfg_prev_r;
    assign load_req_s   = cfg_rise_s | load_cmd_s;

    // Shadow read mux; out-of-range addresses read as zero.
    always_comb begin
        rd_data_s = 16'h0000;
        for (int k = 0; k < NREG; k++) begin
            rd_data_s = (rd_addr_s == 7'(k)) ? shadow_r[k*16 +: 16] : rd_data_s;
        end
    end

    // Two-stage synchronizers, edge registers and post-reset CSN arming.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sck_meta_r  <= 1'b0;
            sck_sync_r  <= 1'b0;
            sck_prev_r  <= 1'b0;
            csn_meta_r  <= 1'b1;
            csn_sync_r  <= 1'b1;
            csn_prev_r  <= 1'b1;
            mosi_meta_r <= 1'b0;
            mosi_sync_r <= 1'b0;
            vld_r       <= 2'b00;
            armed_r     <= 1'b0;
        end else begin
            sck_meta_r  <= spi.SPI_SCK;
            sck_sync_r  <= sck_meta_r;
            sck_prev_r  <= sck_sync_r;
            csn_meta_r  <= spi.SPI_CSN;
            csn_sync_r  <= csn_meta_r;
            csn_prev_r  <= csn_sync_r;
            mosi_meta_r <= spi.SPI_MOSI;
            mosi_sync_r <= mosi_meta_r;
            vld_r       <= {vld_r[0], 1'b1};
            armed_r     <= armed_r | (vld_r[1] & csn_sync_r);
        end
    end

    // Frame FSM state register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Frame FSM next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (csn_fall_s) begin
                    state_s = ST_SHIFT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (csn_rise_s) begin
                    state_s = ST_COMMIT;
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            ST_COMMIT: state_s = ST_IDLE;
            default:   state_s = ST_IDLE;
        endcase
    end

    // Serial shift-in, bit counter and MISO shift-out.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_r     <= 5'd0;
            shift_r   <= 24'h000000;
            miso_sr_r <= 16'h0000;
            miso_r    <= 1'b0;
        end else begin
            if ((state_r == ST_IDLE) && csn_fall_s) begin
                cnt_r     <= 5'd0;
                shift_r   <= 24'h000000;
                miso_sr_r <= 16'h0000;
            end else if ((state_r == ST_SHIFT) && sck_rise_s) begin
                shift_r <= shift_next_s;
                cnt_r   <= (cnt_r == 5'd25) ? cnt_r : cnt_r + 5'd1;
                if (rd_latch_s) begin
                    miso_sr_r <= rd_data_s;
                end
            end else if ((state_r == ST_SHIFT) && sck_fall_s) begin
                miso_sr_r <= {miso_sr_r[14:0], 1'b0};
            end
            if (state_s != ST_SHIFT) begin
                miso_r <= 1'b0;
            end else if ((state_r == ST_SHIFT) && sck_fall_s) begin
                miso_r <= miso_sr_r[15];
            end
        end
    end

    // Shadow bank writes on a complete in-range write frame.
    always_ff @(posedge CLK) begin
        if (RST) begin
            shadow_r <= RST_VAL;
        end else begin
            for (int k = 0; k < NREG; k++) begin
                if (wr_hit_s && (frame_addr_s == 7'(k))) begin
                    shadow_r[k*16 +: 16] <= frame_data_s;
                end
            end
        end
    end

    // Load pipeline: request, atomic copy, then the update pulse.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cfg_prev_r  <= 1'b0;
            load_pend_r <= 1'b0;
            upd_arm_r   <= 1'b0;
            cfg_upd_r   <= 1'b0;
            active_r    <= RST_VAL;
        end else begin
            cfg_prev_r  <= SPI_CONFIG;
            load_pend_r <= load_req_s;
            if (load_pend_r) begin
                active_r <= shadow_r;
            end
            upd_arm_r   <= load_pend_r;
            cfg_upd_r   <= upd_arm_r;
        end
    end

    // Saturating count of frames that were not exactly 24 bits.
    always_ff @(posedge CLK) begin
        if (RST) begin
            abort_r <= 8'h00;
        end else if (abort_s) begin
            abort_r <= sat_inc8(abort_r);
        end
    end

    assign spi.SPI_MISO = miso_r;
    assign CFG_BUS      = active_r;
    assign CFG_UPD      = cfg_upd_r;
    assign ABORT_CNT    = abort_r;

endmodule

// File: tb/tb_spi_cfg_regbank.sv
// Directed bench for spi_cfg_regbank: host frames driven bit by bit, expected
// register contents and timing written out by hand.
module tb_spi_cfg_regbank;

    localparam logic [255:0] RV = 256'h0032 << 48;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         SPI_CONFIG = 1'b0;
    logic [255:0] CFG_BUS;
    logic         CFG_UPD;
    logic [7:0]   ABORT_CNT;
    int           n_cmp = 0;
    int           n_err = 0;

    spi_cfg_regbank_if spi_bus ();

    spi_cfg_regbank #(
        .NREG      (16),
        .RST_VAL   (RV),
        .LOAD_ADDR (7'h7F)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .spi        (spi_bus.slave),
        .SPI_CONFIG (SPI_CONFIG),
        .CFG_BUS    (CFG_BUS),
        .CFG_UPD    (CFG_UPD),
        .ABORT_CNT  (ABORT_CNT)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mk_frame(input logic w, input logic [6:0] addr, input logic [15:0] data);
        return {8'h00, w, addr, data};
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Sends nbits (MSB first); rx collects MISO sampled just before each SCK rise.
    task automatic spi_frame(input logic [31:0] bits, input int nbits, output logic [23:0] rx);
        rx = 24'h000000;
        step(1);
        spi_bus.SPI_CSN = 1'b0;
        step(5);
        for (int i = 0; i < nbits; i++) begin
            spi_bus.SPI_MOSI = bits[nbits-1-i];
            step(5);
            rx = {rx[22:0], spi_bus.SPI_MISO};
            spi_bus.SPI_SCK = 1'b1;
            step(5);
            spi_bus.SPI_SCK = 1'b0;
        end
        spi_bus.SPI_MOSI = 1'b0;
        step(5);
        spi_bus.SPI_CSN = 1'b1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        step(3);
        n_cmp++;
        if (CFG_BUS !== RV) begin
            n_err++;
            $display("FAIL reset_cfg_bus: got %h expected %h", CFG_BUS, RV);
        end
        n_cmp++;
        if (CFG_BUS[63:48] !== 16'h0032) begin
            n_err++;
            $display("FAIL reset_reg3: got %h expected 0032", CFG_BUS[63:48]);
        end
        n_cmp++;
        if (ABORT_CNT !== 8'h00) begin
            n_err++;
            $display("FAIL reset_abort: got %0d expected 0", ABORT_CNT);
        end
        n_cmp++;
        if (CFG_UPD !== 1'b0 || spi_bus.SPI_MISO !== 1'b0) begin
            n_err++;
            $display("FAIL reset_upd_miso: got upd=%b miso=%b expected 0 0", CFG_UPD, spi_bus.SPI_MISO);
        end
        RST = 1'b0;
        step(6);
    endtask

    task automatic test_write_load();
        logic [23:0] rx;
        logic [15:0] exp;
        int          upd_seen;
        spi_frame(mk_frame(1'b1, 7'd2, 16'hA5C3), 24, rx);
        step(8);
        n_cmp++;
        if (CFG_BUS[47:32] !== 16'h0000) begin
            n_err++;
            $display("FAIL shadow_only: got %h expected 0000", CFG_BUS[47:32]);
        end
        n_cmp++;
        if (rx !== 24'h000000) begin
            n_err++;
            $display("FAIL write_miso_quiet: got %h expected 000000", rx);
        end
        spi_frame(mk_frame(1'b1, 7'h7F, 16'hFFFF), 24, rx);
        upd_seen = 0;
        for (int c = 1; c <= 9; c++) begin
            step(1);
            exp = (c >= 5) ? 16'hA5C3 : 16'h0000;
            n_cmp++;
            if (CFG_BUS[47:32] !== exp) begin
                n_err++;
                $display("FAIL load_latency_c%0d: got %h expected %h", c, CFG_BUS[47:32], exp);
            end
            n_cmp++;
            if (CFG_UPD !== (c == 6)) begin
                n_err++;
                $display("FAIL upd_timing_c%0d: got %b expected %b", c, CFG_UPD, (c == 6));
            end
            if (CFG_UPD === 1'b1) upd_seen++;
        end
        n_cmp++;
        if (upd_seen != 1 || CFG_BUS[63:48] !== 16'h0032) begin
            n_err++;
            $display("FAIL load_single_pulse: got pulses=%0d reg3=%h expected 1 0032", upd_seen, CFG_BUS[63:48]);
        end
    endtask

    task automatic test_config_load();
        logic [23:0] rx;
        logic [31:0] exp;
        int          upd_seen;
        spi_frame(mk_frame(1'b1, 7'd4, 16'h1234), 24, rx);
        step(8);
        spi_frame(mk_frame(1'b1, 7'd5, 16'h5678), 24, rx);
        step(8);
        n_cmp++;
        if (CFG_BUS[95:64] !== 32'h0000_0000) begin
            n_err++;
            $display("FAIL cfg_preload: got %h expected 00000000", CFG_BUS[95:64]);
        end
        SPI_CONFIG = 1'b1;
        upd_seen = 0;
        for (int c = 1; c <= 8; c++) begin
            step(1);
            if (c == 3) SPI_CONFIG = 1'b0;
            exp = (c >= 2) ? 32'h5678_1234 : 32'h0000_0000;
            n_cmp++;
            if (CFG_BUS[95:64] !== exp) begin
                n_err++;
                $display("FAIL cfg_load_c%0d: got %h expected %h", c, CFG_BUS[95:64], exp);
            end
            n_cmp++;
            if (CFG_UPD !== (c == 3)) begin
                n_err++;
                $display("FAIL cfg_upd_c%0d: got %b expected %b", c, CFG_UPD, (c == 3));
            end
            if (CFG_UPD === 1'b1) upd_seen++;
        end
        n_cmp++;
        if (upd_seen != 1) begin
            n_err++;
            $display("FAIL cfg_single_pulse: got %0d expected 1", upd_seen);
        end
    endtask

    task automatic test_read();
        logic [23:0] rx;
        spi_frame(mk_frame(1'b1, 7'd1, 16'hBEEF), 24, rx);
        step(8);
        spi_frame(mk_frame(1'b0, 7'd1, 16'h0000), 24, rx);
        step(8);
        n_cmp++;
        if (rx !== 24'h00BEEF) begin
            n_err++;
            $display("FAIL read_addr1: got %h expected 00beef", rx);
        end
        spi_frame(mk_frame(1'b0, 7'd2, 16'h0000), 24, rx);
        step(8);
        n_cmp++;
        if (rx !== 24'h00A5C3) begin
            n_err++;
            $display("FAIL read_addr2: got %h expected 00a5c3", rx);
        end
        spi_frame(mk_frame(1'b0, 7'd40, 16'h0000), 24, rx);
        step(8);
        n_cmp++;
        if (rx !== 24'h000000) begin
            n_err++;
            $display("FAIL read_out_of_range: got %h expected 000000", rx);
        end
        n_cmp++;
        if (spi_bus.SPI_MISO !== 1'b0 || ABORT_CNT !== 8'h00) begin
            n_err++;
            $display("FAIL read_idle: got miso=%b abort=%0d expected 0 0", spi_bus.SPI_MISO, ABORT_CNT);
        end
    endtask

    task automatic test_abort();
        logic [23:0] rx;
        logic [31:0] f;
        f = mk_frame(1'b1, 7'd6, 16'h6666);
        spi_frame(f >> 11, 13, rx);
        step(8);
        f = mk_frame(1'b1, 7'd7, 16'h7777);
        spi_frame((f << 2) | 32'h3, 26, rx);
        step(8);
        n_cmp++;
        if (ABORT_CNT !== 8'd2) begin
            n_err++;
            $display("FAIL abort_two: got %0d expected 2", ABORT_CNT);
        end
        spi_frame(mk_frame(1'b0, 7'd6, 16'h0000), 24, rx);
        step(8);
        n_cmp++;
        if (rx !== 24'h000000) begin
            n_err++;
            $display("FAIL truncated_no_write: got %h expected 000000", rx);
        end
        spi_frame(mk_frame(1'b0, 7'd7, 16'h0000), 24, rx);
        step(8);
        n_cmp++;
        if (rx !== 24'h000000) begin
            n_err++;
            $display("FAIL overlong_no_write: got %h expected 000000", rx);
        end
        for (int i = 0; i < 300; i++) begin
            spi_frame(32'h1, 1, rx);
            step(6);
        end
        n_cmp++;
        if (ABORT_CNT !== 8'd255) begin
            n_err++;
            $display("FAIL abort_saturate: got %0d expected 255", ABORT_CNT);
        end
    endtask

    task automatic test_reset_midframe();
        logic [23:0] rx;
        logic [31:0] f;
        f = mk_frame(1'b1, 7'd8, 16'h1111);
        step(1);
        spi_bus.SPI_CSN = 1'b0;
        step(5);
        for (int i = 0; i < 24; i++) begin
            if (i == 10) begin
                RST = 1'b1;
                step(2);
                RST = 1'b0;
            end
            spi_bus.SPI_MOSI = f[23-i];
            step(5);
            spi_bus.SPI_SCK = 1'b1;
            step(5);
            spi_bus.SPI_SCK = 1'b0;
        end
        step(5);
        spi_bus.SPI_CSN = 1'b1;
        step(8);
        n_cmp++;
        if (ABORT_CNT !== 8'h00) begin
            n_err++;
            $display("FAIL midreset_abort: got %0d expected 0", ABORT_CNT);
        end
        spi_frame(mk_frame(1'b0, 7'd8, 16'h0000), 24, rx);
        step(8);
        n_cmp++;
        if (rx !== 24'h000000) begin
            n_err++;
            $display("FAIL midreset_no_write: got %h expected 000000", rx);
        end
        spi_frame(mk_frame(1'b1, 7'd8, 16'h4242), 24, rx);
        step(8);
        spi_frame(mk_frame(1'b1, 7'h7F, 16'h0000), 24, rx);
        step(8);
        n_cmp++;
        if (CFG_BUS[143:128] !== 16'h4242 || CFG_BUS[63:48] !== 16'h0032 || CFG_BUS[47:32] !== 16'h0000) begin
            n_err++;
            $display("FAIL midreset_clean_frame: got r8=%h r3=%h r2=%h expected 4242 0032 0000",
                     CFG_BUS[143:128], CFG_BUS[63:48], CFG_BUS[47:32]);
        end
        n_cmp++;
        if (ABORT_CNT !== 8'h00) begin
            n_err++;
            $display("FAIL midreset_abort_after: got %0d expected 0", ABORT_CNT);
        end
    endtask

    initial begin
        spi_bus.SPI_SCK  = 1'b0;
        spi_bus.SPI_CSN  = 1'b1;
        spi_bus.SPI_MOSI = 1'b0;
        test_reset();
        test_write_load();
        test_config_load();
        test_read();
        test_abort();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
